// File: rtl/alarma_ctrl.sv
// Intruder alarm controller: exit/entry delays, siren timer and auto re-arm.
// Sensor pins are asynchronous and pass through a 2-flop synchronizer before use.
module alarma_ctrl #(
   parameter int unsigned T_SALIDA  = 10,
   parameter int unsigned T_ENTRADA = 8,
   parameter int unsigned T_SIRENA  = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       armar,
   input  logic       desarmar,
   input  logic [2:0] sensores,
   output logic       sirena,
   output logic       armada,
   output logic [2:0] estado,
   output logic [7:0] cuenta
);

   typedef enum logic [2:0] {
      DESARMADA = 3'b000,
      SALIDA    = 3'b001,
      ARMADA    = 3'b010,
      ENTRADA   = 3'b011,
      ALARMA    = 3'b100
   } state_t;

   localparam logic [7:0] LD_SALIDA  = 8'(T_SALIDA - 1);
   localparam logic [7:0] LD_ENTRADA = 8'(T_ENTRADA - 1);
   localparam logic [7:0] LD_SIRENA  = 8'(T_SIRENA - 1);

   logic [2:0] sync_1, sync_2;
   state_t     state_q, state_d;
   logic [7:0] cuenta_q, cuenta_d;
   logic       sirena_q, armada_q;
   logic       sen_a, sen_ventana, expirado;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1 <= 3'b000;
         sync_2 <= 3'b000;
      end else begin
         sync_1 <= sensores;
         sync_2 <= sync_1;
      end
   end

   assign sen_a       = sync_2[2];
   assign sen_ventana = sync_2[1] | sync_2[0];
   assign expirado    = (cuenta_q == 8'd0);

   always_comb begin
      state_d  = state_q;
      cuenta_d = 8'd0;
      case (state_q)
         DESARMADA: begin
            if (armar) begin
               state_d  = SALIDA;
               cuenta_d = LD_SALIDA;
            end
         end
         SALIDA: begin
            if (expirado) state_d = ARMADA;
            else          cuenta_d = cuenta_q - 8'd1;
         end
         ARMADA: begin
            // Window sensors outrank the door: no entry grace period for them.
            if (sen_ventana) begin
               state_d  = ALARMA;
               cuenta_d = LD_SIRENA;
            end else if (sen_a) begin
               state_d  = ENTRADA;
               cuenta_d = LD_ENTRADA;
            end
         end
         ENTRADA: begin
            if (sen_ventana || expirado) begin
               state_d  = ALARMA;
               cuenta_d = LD_SIRENA;
            end else begin
               cuenta_d = cuenta_q - 8'd1;
            end
         end
         ALARMA: begin
            if (expirado) state_d = ARMADA;
            else          cuenta_d = cuenta_q - 8'd1;
         end
         default: begin
            state_d  = DESARMADA;
            cuenta_d = 8'd0;
         end
      endcase
      // Disarm overrides everything, including a simultaneous arm request.
      if (desarmar) begin
         state_d  = DESARMADA;
         cuenta_d = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= DESARMADA;
         cuenta_q <= 8'd0;
         sirena_q <= 1'b0;
         armada_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cuenta_q <= cuenta_d;
         sirena_q <= (state_d == ALARMA);
         armada_q <= (state_d == ARMADA) || (state_d == ENTRADA) || (state_d == ALARMA);
      end
   end

   assign estado = state_q;
   assign cuenta = cuenta_q;
   assign sirena = sirena_q;
   assign armada = armada_q;

endmodule

// File: tb/tb_alarma_ctrl.sv
// Bench for alarma_ctrl: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based model of the alarm's phases.
module tb_alarma_ctrl;

   localparam int T_SAL = 10;
   localparam int T_ENT = 8;
   localparam int T_SIR = 20;

   localparam int ST_DES = 0;
   localparam int ST_SAL = 1;
   localparam int ST_ARM = 2;
   localparam int ST_ENT = 3;
   localparam int ST_ALM = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       armar = 1'b0;
   logic       desarmar = 1'b0;
   logic [2:0] sensores = 3'b000;
   logic       sirena, armada;
   logic [2:0] estado;
   logic [7:0] cuenta;

   int tests_run = 0;
   int tests_failed = 0;

   // model: current phase, edge index at which it was entered, pin history
   int         m_st;
   int         m_start;
   int         edge_n;
   logic [2:0] pin_q[$];
   logic       sir_seen;

   alarma_ctrl #(.T_SALIDA(T_SAL), .T_ENTRADA(T_ENT), .T_SIRENA(T_SIR)) dut (
      .clk(clk), .reset(reset), .armar(armar), .desarmar(desarmar),
      .sensores(sensores), .sirena(sirena), .armada(armada),
      .estado(estado), .cuenta(cuenta)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int phase_len(input int st);
      case (st)
         ST_SAL:  return T_SAL;
         ST_ENT:  return T_ENT;
         ST_ALM:  return T_SIR;
         default: return 0;
      endcase
   endfunction

   // Counter value derived from time spent in the phase
   function automatic int model_cuenta();
      if (phase_len(m_st) == 0) return 0;
      return phase_len(m_st) - 1 - (edge_n - m_start);
   endfunction

   task automatic model_reset();
      m_st    = ST_DES;
      m_start = 0;
      edge_n  = 0;
      pin_q   = {3'b000, 3'b000};
   endtask

   task automatic model_edge();
      logic [2:0] s;
      int         nxt;
      bit         done;
      s = pin_q.pop_front();
      pin_q.push_back(sensores);
      done = (phase_len(m_st) != 0) && (model_cuenta() == 0);
      nxt = m_st;
      if (desarmar) nxt = ST_DES;
      else if (m_st == ST_DES && armar) nxt = ST_SAL;
      else if (m_st == ST_SAL && done) nxt = ST_ARM;
      else if (m_st == ST_ARM && (s[1] || s[0])) nxt = ST_ALM;
      else if (m_st == ST_ARM && s[2]) nxt = ST_ENT;
      else if (m_st == ST_ENT && (s[1] || s[0] || done)) nxt = ST_ALM;
      else if (m_st == ST_ALM && done) nxt = ST_ARM;
      edge_n++;
      if (nxt != m_st) begin
         m_st    = nxt;
         m_start = edge_n;
      end
   endtask

   task automatic compare_model();
      check("estado", 32'(estado), 32'(m_st));
      check("cuenta", 32'(cuenta), 32'(model_cuenta()));
      check("sirena", 32'(sirena), 32'(m_st == ST_ALM));
      check("armada", 32'(armada), 32'(m_st == ST_ARM || m_st == ST_ENT || m_st == ST_ALM));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_model();
      if (sirena === 1'b1) sir_seen = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_estado", 32'(estado), 32'd0);
      check("rst_cuenta", 32'(cuenta), 32'd0);
      check("rst_sirena", 32'(sirena), 32'd0);
      check("rst_armada", 32'(armada), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("rst_hold", 32'(estado), 32'd0);
      reset = 1'b0;
   endtask

   // Ticks until estado reaches code; the tick count is compared to exp_n
   task automatic wait_state(input string tag, input logic [2:0] code, input int exp_n);
      int n;
      n = 0;
      while (estado !== code && n < 300) begin
         tick();
         n++;
      end
      check(tag, 32'(n), 32'(exp_n));
   endtask

   task automatic arm_now();
      armar = 1'b1;
      tick();
      armar = 1'b0;
      wait_state("arm_to_armada", 3'b010, T_SAL);
   endtask

   initial begin
      int n;
      #1;
      do_reset();

      // arm: SALIDA next cycle, ARMADA 10 cycles later
      armar = 1'b1;
      tick();
      armar = 1'b0;
      check("arm_salida", 32'(estado), 32'd1);
      check("arm_cuenta", 32'(cuenta), 32'(T_SAL - 1));
      wait_state("salida_len", 3'b010, T_SAL);
      check("armada_hi", 32'(armada), 32'd1);

      // door entry, then disarm at cuenta=4
      sir_seen = 1'b0;
      sensores = 3'b100;
      tick();
      tick();
      check("sync_lat", 32'(estado), 32'd2);
      tick();
      check("entrada", 32'(estado), 32'd3);
      check("entrada_cnt", 32'(cuenta), 32'(T_ENT - 1));
      sensores = 3'b000;
      n = 0;
      while (cuenta !== 8'd4 && n < 50) begin
         tick();
         n++;
      end
      check("reach_cnt4", 32'(cuenta), 32'd4);
      desarmar = 1'b1;
      tick();
      desarmar = 1'b0;
      check("disarm_est", 32'(estado), 32'd0);
      check("disarm_cnt", 32'(cuenta), 32'd0);
      check("no_siren", 32'(sir_seen), 32'd0);

      // entry timeout, siren period, auto re-arm
      arm_now();
      sensores = 3'b100;
      tick();
      tick();
      tick();
      check("entrada2", 32'(estado), 32'd3);
      sensores = 3'b000;
      wait_state("entrada_len", 3'b100, T_ENT);
      wait_state("sirena_len", 3'b010, T_SIR);
      check("rearm_sir", 32'(sirena), 32'd0);
      check("rearm_arm", 32'(armada), 32'd1);

      // window priority over door
      sensores = 3'b111;
      tick();
      tick();
      check("win_pre", 32'(estado), 32'd2);
      tick();
      check("win_alarm", 32'(estado), 32'd4);
      check("win_cnt", 32'(cuenta), 32'd19);
      sensores = 3'b000;

      // simultaneous arm+disarm in ALARMA, then in DESARMADA
      armar = 1'b1;
      desarmar = 1'b1;
      tick();
      check("both_alm", 32'(estado), 32'd0);
      check("both_sir", 32'(sirena), 32'd0);
      tick();
      check("both_des", 32'(estado), 32'd0);
      armar = 1'b0;
      desarmar = 1'b0;

      // asynchronous reset mid-ALARMA at cuenta=7
      arm_now();
      sensores = 3'b001;
      tick();
      tick();
      tick();
      sensores = 3'b000;
      check("c_alarm", 32'(estado), 32'd4);
      n = 0;
      while (cuenta !== 8'd7 && n < 50) begin
         tick();
         n++;
      end
      check("reach_cnt7", 32'(cuenta), 32'd7);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stay_des", 32'(estado), 32'd0);
      end

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         armar    = ($urandom_range(0, 19) == 0);
         desarmar = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 7) == 0)
            sensores = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         if ($urandom_range(0, 599) == 0) do_reset();
         else tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alarma_ctrl.md
ALARMA_CTRL -- requirements
Module: alarma_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter T_SALIDA, default 10, SHALL set the exit delay in clock cycles (range 1..255).
REQ-003 Parameter T_ENTRADA, default 8, SHALL set the entry delay in clock cycles (range 1..255).
REQ-004 Parameter T_SIRENA, default 20, SHALL set the siren-on time in clock cycles (range 1..255).
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 Port armar, input, 1 bit: arm request, level-sampled each cycle.
REQ-008 Port desarmar, input, 1 bit: disarm request, level-sampled each cycle.
REQ-009 Port sensores, input, 3 bits:
- bit2 = A, door sensor.
- bit1 = B, window sensor.
- bit0 = C, window sensor.
- Active-high; asynchronous to clk.
REQ-010 Port sirena, output, 1 bit: siren drive.
REQ-011 Port armada, output, 1 bit: high in ARMADA, ENTRADA and ALARMA.
REQ-012 Port estado, output, 3 bits: current state encoding.
REQ-013 Port cuenta, output, 8 bits: current delay/siren counter value.

Function
REQ-014 sensores SHALL pass through a 2-flop synchronizer; internal sensor s = synchronized value, 2 cycles latency from pin.
REQ-015 The FSM SHALL use encodings DESARMADA=000, SALIDA=001, ARMADA=010, ENTRADA=011, ALARMA=100; other codes SHALL return to DESARMADA on the next edge.
REQ-016 In DESARMADA with armar=1 and desarmar=0, next state SHALL be SALIDA, with cuenta loaded to T_SALIDA-1.
REQ-017 In SALIDA, cuenta SHALL decrement by 1 per cycle.
- Sensors are ignored in SALIDA.
- At cuenta=0, next state SHALL be ARMADA.
REQ-018 In ARMADA, the following SHALL apply:
- s.B=1 or s.C=1: next state ALARMA, cuenta loaded to T_SIRENA-1.
- Else s.A=1: next state ENTRADA, cuenta loaded to T_ENTRADA-1.
- B/C takes priority over A.
REQ-019 In ENTRADA, cuenta SHALL decrement by 1 per cycle.
- s.B=1 or s.C=1: immediate transition to ALARMA, cuenta loaded to T_SIRENA-1.
- At cuenta=0: next state ALARMA, cuenta loaded to T_SIRENA-1.
REQ-020 In ALARMA, sirena SHALL be 1 and cuenta SHALL decrement by 1 per cycle.
- At cuenta=0, next state SHALL be ARMADA (auto re-arm).
- Any sensor still active re-triggers from ARMADA per REQ-018.
REQ-021 desarmar=1 SHALL force next state DESARMADA from every state.
- desarmar takes priority over armar, sensors and counter expiry.
- cuenta is cleared to 0 on that transition.
REQ-022 armar SHALL be ignored in every state except DESARMADA.
REQ-023 sirena and armada SHALL be registered (Moore) outputs decoded from the current state.
- Both change on the same edge as estado.
REQ-024 cuenta SHALL be 0 and hold in DESARMADA and ARMADA.
- cuenta SHALL never wrap below 0.

Reset
REQ-025 While reset=1, the block SHALL hold: estado=000, cuenta=0, sirena=0, armada=0, synchronizer flops=0.
- This applies asynchronously, including mid-countdown.
REQ-026 After reset deassertion, the first state change SHALL occur no earlier than the first rising clk edge.

Verification
REQ-027 Arm: armar=1 for 1 cycle from DESARMADA.
- Response: estado=001 next cycle.
- estado=010 exactly 10 cycles after entering SALIDA.
- armada=1 from that edge.
REQ-028 Entry then disarm: in ARMADA, sensores=100 (A only).
- Response: estado=011 3 cycles after the pin change (2 sync + 1).
- desarmar=1 at cuenta=4 gives estado=000, sirena never 1.
REQ-029 Entry timeout: in ARMADA, sensores=100 with no disarm.
- Response: ALARMA 8 cycles after entering ENTRADA.
- sirena=1 for 20 cycles, then estado=010.
REQ-030 Window priority: in ARMADA, sensores=111.
- Response: estado goes 010 -> 100 directly, skipping ENTRADA.
- cuenta=19 on entry.
REQ-031 Simultaneous requests: armar=1 and desarmar=1 in DESARMADA.
- Response: stays 000.
- Same inputs in ALARMA: goes to 000 and sirena drops on that edge.
REQ-032 Reset mid-ALARMA at cuenta=7.
- Response: estado=000, cuenta=0, sirena=0 immediately, without waiting for clk.
- Remains so until armar is asserted.
